// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and character-width decoding,
// common to uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_e;

    // Index of the last data bit: 00->4 (5 bits) .. 11->7 (8 bits).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        return 3'd4 + {1'b0, bits};
    endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Bit-period timer: counts 0..div and flags bit_done on the last cycle of
// each period, so every bit lasts div+1 clocks.
module uart_baudgen (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        bit_done
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // bit_done must not depend on clear: clear is derived from the next
    // state, which itself depends on bit_done.
    assign bit_done = enable & (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || !enable || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional even parity,
// 1 or 2 stop bits. Frame configuration is captured when a character is accepted.
module uart_tx
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        tx_o,
    output logic        busy_o,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_en_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o
);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  bits_q, bits_d;
    logic        par_en_q, par_en_d;
    logic        stop2_q, stop2_d;

    logic        bit_done;
    logic        accept;
    logic        last_bit;

    assign tx_ready_o = (state_q == IDLE) & cfg_en_i & ~rst_i;
    assign accept     = tx_valid_i & tx_ready_o;
    assign last_bit   = (bit_cnt_q == last_bit_idx(bits_q));
    assign busy_o     = (state_q != IDLE);
    assign tx_o       = tx_q;

    uart_baudgen u_baudgen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable   (cfg_en_i & (state_q != IDLE)),
        .clear    (state_d != state_q),
        .div      (div_q),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= 8'hFF;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            div_q     <= '0;
            bits_q    <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept)   state_d = START;
                START:   if (bit_done) state_d = DATA;
                DATA:    if (bit_done && last_bit) state_d = par_en_q ? PARITY : STOP1;
                PARITY:  if (bit_done) state_d = STOP1;
                STOP1:   if (bit_done) state_d = stop2_q ? STOP2 : IDLE;
                STOP2:   if (bit_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        div_d     = div_q;
        bits_d    = bits_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;

        if (!cfg_en_i) begin
            bit_cnt_d = '0;
            parity_d  = 1'b0;
        end else if (accept) begin
            shift_d   = tx_data_i;
            bit_cnt_d = '0;
            parity_d  = 1'b0;
            div_d     = cfg_div_i;
            bits_d    = cfg_bits_i;
            par_en_d  = cfg_parity_en_i;
            stop2_d   = cfg_stop_bits_i;
        end else if (state_q == DATA && bit_done) begin
            parity_d  = parity_q ^ shift_q[0];
            shift_d   = {1'b1, shift_q[7:1]};
            bit_cnt_d = last_bit ? 3'd0 : bit_cnt_q + 3'd1;
        end

        // Line level follows the state being entered so tx_o moves on the
        // same edge as the state change.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: expected line waveforms are
// hand-computed frame bit vectors (bit i = i-th bit on the line).
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx;
    logic        busy;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        cfg_parity_en;
    logic [1:0]  cfg_bits;
    logic        cfg_stop_bits;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .tx_o            (tx),
        .busy_o          (busy),
        .cfg_div_i       (cfg_div),
        .cfg_en_i        (cfg_en),
        .cfg_parity_en_i (cfg_parity_en),
        .cfg_bits_i      (cfg_bits),
        .cfg_stop_bits_i (cfg_stop_bits),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Walks one frame already accepted; optionally changes cfg_div mid-frame.
    task automatic check_frame(input string tag, input logic [11:0] frame,
                               input int nbits, input int div, input int chg_at);
        for (int i = 0; i < nbits * (div + 1); i++) begin
            if (i == chg_at) cfg_div = 16'd9;
            chk({tag, "_tx"}, tx, frame[i / (div + 1)]);
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_ready"}, tx_ready, 1'b0);
            step();
        end
        chk({tag, "_end_tx"}, tx, 1'b1);
        chk({tag, "_end_busy"}, busy, 1'b0);
        chk({tag, "_end_ready"}, tx_ready, 1'b1);
        $display("frame %s: %0d bits of %0d cycles checked", tag, nbits, div + 1);
    endtask

    task automatic send(input string tag, input logic [7:0] d, input logic [11:0] frame,
                        input int nbits, input int div);
        tx_data  = d;
        tx_valid = 1'b1;
        #1;
        chk({tag, "_ready_pre"}, tx_ready, 1'b1);
        step();
        tx_valid = 1'b0;
        check_frame(tag, frame, nbits, div, -1);
    endtask

    initial begin
        rst           = 1'b1;
        cfg_en        = 1'b1;
        cfg_div       = 16'd3;
        cfg_parity_en = 1'b0;
        cfg_bits      = 2'b11;
        cfg_stop_bits = 1'b0;
        tx_data       = 8'h00;
        tx_valid      = 1'b0;
        step();
        step();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", tx_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", tx_ready, 1'b1);

        // 8N1, div=3, A5
        send("a5_8n1", 8'hA5, 12'b0011_0100_1010, 10, 3);

        // 7E1, div=1
        cfg_div = 16'd1; cfg_bits = 2'b10; cfg_parity_en = 1'b1;
        send("55_7e1", 8'h55, 12'b0010_1010_1010, 10, 1);
        send("5f_7e1", 8'h5F, 12'b0010_1011_1110, 10, 1);
        send("07_7e1", 8'h07, 12'b0011_0000_1110, 10, 1);

        // 5E2, div=0, upper bits ignored
        cfg_div = 16'd0; cfg_bits = 2'b00; cfg_stop_bits = 1'b1;
        send("ff_5e2", 8'hFF, 12'b0001_1111_1110, 9, 0);

        // Back-to-back with mid-frame div change
        cfg_div = 16'd2; cfg_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop_bits = 1'b0;
        tx_data = 8'h3C; tx_valid = 1'b1;
        #1;
        chk("b2b_ready_pre", tx_ready, 1'b1);
        step();
        tx_data = 8'hC3;
        check_frame("b2b_3c", 12'b0010_0111_1000, 10, 2, 5);
        step();
        tx_valid = 1'b0;
        check_frame("b2b_c3", 12'b0011_1000_0110, 10, 9, -1);

        // Enable dropped during DATA
        cfg_div = 16'd3;
        tx_data = 8'hA5; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (10) step();
        chk("en_mid_busy", busy, 1'b1);
        cfg_en = 1'b0;
        #1;
        chk("en_low_ready", tx_ready, 1'b0);
        step();
        chk("en_drop_tx", tx, 1'b1);
        chk("en_drop_busy", busy, 1'b0);
        chk("en_drop_ready", tx_ready, 1'b0);
        tx_valid = 1'b1;
        step();
        step();
        chk("en_low_valid_tx", tx, 1'b1);
        chk("en_low_valid_busy", busy, 1'b0);
        chk("en_low_valid_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        cfg_en = 1'b1;
        $display("enable drop: line idled and no accept while disabled");
        send("0f_after_en", 8'h0F, 12'b0010_0001_1110, 10, 3);

        // Reset pulsed mid-frame
        tx_data = 8'h0F; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (15) step();
        chk("rst_mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", tx_ready, 1'b0);
        step();
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy_after", busy, 1'b0);
        chk("rst_mid_ready_after", tx_ready, 1'b0);
        rst = 1'b0;
        $display("mid-frame reset: line idled");
        send("a5_after_rst", 8'hA5, 12'b0011_0100_1010, 10, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
